// File: rtl/rx_frame_receiver.sv
// Serial frame receiver: hunts for a rising start edge, samples NBIT data bits
// MSB first at mid-bit using the shared ce tick, and checks the low stop bit.
module rx_frame_receiver #(
    parameter int NP   = 8,
    parameter int NBIT = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ce,
    input  logic            rx,
    output logic [NBIT-1:0] dat,
    output logic            ok,
    output logic            err,
    output logic            ce_bit,
    output logic            en_rx
);

    localparam int TW = $clog2(NP);
    localparam int BW = $clog2(NBIT + 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t          state;
    logic            rx_m;
    logic            rx_s;
    logic            rx_p;
    logic [TW-1:0]   cb_tick;
    logic [BW-1:0]   cb_bit;
    logic [NBIT-1:0] sh;
    logic [NBIT:0]   sh_ext;
    logic            rise;

    // Concatenating through a wider vector keeps the shift legal for NBIT == 1.
    assign sh_ext = {sh, rx_s};
    assign rise   = rx_s & ~rx_p;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            rx_m    <= 1'b0;
            rx_s    <= 1'b0;
            rx_p    <= 1'b0;
            cb_tick <= '0;
            cb_bit  <= '0;
            sh      <= '0;
            dat     <= '0;
            ok      <= 1'b0;
            err     <= 1'b0;
            ce_bit  <= 1'b0;
            en_rx   <= 1'b0;
        end else begin
            rx_m   <= rx;
            rx_s   <= rx_m;
            rx_p   <= rx_s;
            ok     <= 1'b0;
            err    <= 1'b0;
            ce_bit <= 1'b0;

            case (state)
                IDLE: begin
                    if (rise) begin
                        state   <= START;
                        cb_tick <= '0;
                        en_rx   <= 1'b1;
                    end
                end

                // A start bit that has already dropped at its midpoint is a glitch.
                START: begin
                    if (ce) begin
                        if (cb_tick == TW'(NP / 2 - 1)) begin
                            ce_bit  <= 1'b1;
                            cb_tick <= '0;
                            cb_bit  <= '0;
                            if (rx_s) begin
                                state <= DATA;
                            end else begin
                                state <= IDLE;
                                en_rx <= 1'b0;
                            end
                        end else begin
                            cb_tick <= cb_tick + TW'(1);
                        end
                    end
                end

                DATA: begin
                    if (ce) begin
                        if (cb_tick == TW'(NP - 1)) begin
                            ce_bit  <= 1'b1;
                            sh      <= sh_ext[NBIT-1:0];
                            cb_tick <= '0;
                            cb_bit  <= cb_bit + BW'(1);
                            if (cb_bit == BW'(NBIT - 1)) begin
                                state <= STOP;
                            end
                        end else begin
                            cb_tick <= cb_tick + TW'(1);
                        end
                    end
                end

                STOP: begin
                    if (ce) begin
                        if (cb_tick == TW'(NP - 1)) begin
                            ce_bit  <= 1'b1;
                            cb_tick <= '0;
                            state   <= IDLE;
                            en_rx   <= 1'b0;
                            if (!rx_s) begin
                                dat <= sh;
                                ok  <= 1'b1;
                            end else begin
                                err <= 1'b1;
                            end
                        end else begin
                            cb_tick <= cb_tick + TW'(1);
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                    en_rx <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/rx_frame_receiver.md
Name: rx_frame_receiver

Overview:
- Receive-side counterpart of the serial frame transmitter timer.
- Hunts for a start bit on the serial line and recovers bit timing from the shared `ce` tick. Samples NBIT data bits mid-bit, checks the stop bit and presents the assembled word with a one-clock valid or error pulse.
- Sits between the line input pin and the downstream word consumer, in the same clock/`ce` domain as the transmitter.

Parameters:
- NP, 8, `ce` ticks per bit period; must be even and >= 4.
- NBIT, 8, data bits per frame; range 1..32.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- ce  in  1  tick enable; all bit timing counts `ce` cycles only.
- rx  in  1  serial line. Idle = 0; frame = start bit 1, NBIT data bits MSB first, stop bit 0.
- dat  out  NBIT  last correctly received word.
- ok  out  1  one-clk pulse: `dat` updated with a good frame.
- err  out  1  one-clk pulse: frame aborted on bad stop bit.
- ce_bit  out  1  one-clk strobe at every sample point (start check, each data bit, stop).
- en_rx  out  1  high while a frame is in progress (states START, DATA, STOP).

Behaviour:
- Input conditioning:
  - `rx` passes through a 2-flop synchronizer to give `rx_s`; a previous-value flop gives `rx_p`.
  - Synchronizer and edge flops update every clk, independent of `ce`.
  - Rising edge is `rx_s & !rx_p`.
- Counters:
  - `cb_tick` is clog2(NP) bits wide and increments only when `ce`=1.
  - `cb_bit` is clog2(NBIT+1) bits wide.
- State IDLE:
  - `en_rx`=0.
  - On a rising edge: go to START and set `cb_tick`<=0.
  - `ce` is not required for the transition.
- State START:
  - When `ce` & `cb_tick`==NP/2-1: `ce_bit`=1 and `rx_s` is sampled.
  - `rx_s`=1: go to DATA; `cb_tick`<=0, `cb_bit`<=0.
  - `rx_s`=0 (glitch): return to IDLE silently, with no `err`.
- State DATA:
  - When `ce` & `cb_tick`==NP-1: `ce_bit`=1.
  - Shift register takes `{sh[NBIT-2:0], rx_s}`.
  - `cb_tick`<=0, `cb_bit`<=`cb_bit`+1.
  - At the strobe where `cb_bit`==NBIT-1: go to STOP.
- State STOP:
  - When `ce` & `cb_tick`==NP-1: `ce_bit`=1 and stop bit is sampled.
  - `rx_s`=0: `dat`<=shift register, `ok`=1 on the next clk, go to IDLE.
  - `rx_s`=1: `err`=1 on the next clk, `dat` unchanged, go to IDLE.
- Samples fall at mid-bit: start check at NP/2 ticks after the edge, each subsequent sample NP ticks later.
- `ok`/`err` latency: exactly one clk after the stop-sample clk. The two are never asserted together.
- Re-arm:
  - IDLE needs a fresh rising edge, so a line stuck high after `err` produces no new frame until it returns low and rises again.
  - A frame starting immediately after a stop bit (one idle bit) is received correctly.
- Edges seen in START, DATA or STOP are ignored; there is no resynchronization mid-frame.
- `ce` held low freezes all counters and the state. The synchronizer keeps running.
- Reset, mid-frame or not:
  - Outputs: `dat`=0, `ok`=0, `err`=0, `ce_bit`=0, `en_rx`=0.
  - State IDLE, all counters 0, synchronizer/edge flops 0.
  - A partially received frame is discarded with no pulse.

Test Plan:
- NP=8, NBIT=8, `ce`=1 constantly; send frame 0xA5 with stop 0 -> single `ok` pulse, `dat`=0xA5. 10 `ce_bit` strobes each at mid-bit (first 4 ticks after edge + sync delay); `en_rx` high throughout.
- `rx` high for 2 `ce` ticks, then low -> no `ok`, no `err`, `en_rx` drops after the START sample; a following 0x3C frame gives `dat`=0x3C.
- Frame 0x5A with stop bit driven 1 -> `err` pulse one clk after stop sample, `dat` keeps previous 0x3C. Line left high -> no new frame until a low-then-high transition.
- Assert `rst` for one clk during data bit 4 of frame 0xFF -> all outputs 0 next clk. Subsequent frame 0x81 -> `ok`, `dat`=0x81.
- Two frames 0x01 and 0xFE separated by exactly one idle bit -> two `ok` pulses, `dat` sequence 0x01 then 0xFE.
- `ce` asserted 1-in-4 clocks, transmitter on the same `ce`, frame 0xC3 -> `ok`, `dat`=0xC3; sample strobes spaced 32 clks apart.
